// File: rtl/keypoint_collector.sv
// keypoint_collector: captures flagged FAST keypoints of one frame into a
// first-word-fall-through FIFO and hands them out over valid/ready.
// Optional build macro KPC_SCORE_THRESH_EN adds i_min_score, a minimum
// score below which flagged points are silently discarded.
//
// state   | meaning
// IDLE    | waiting for i_start, o_ready high
// COLLECT | flagged points are pushed until i_end
// DRAIN   | no pushes; waits for FIFO empty, then pulses o_done
module keypoint_collector #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int MAX_KP = 500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_end,
  input  logic        i_flag,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic [7:0]  i_score,
  input  logic [11:0] i_cos,
  input  logic [11:0] i_sin,
`ifdef KPC_SCORE_THRESH_EN
  input  logic [7:0]  i_min_score,
`endif
  output logic        o_ready,
  output logic        o_valid,
  output logic [51:0] o_data,
  input  logic        i_rd_ready,
  output logic [15:0] o_kp_count,
  output logic        o_overflow,
  output logic        o_done
);

  localparam logic [15:0] MAX_KP_C = 16'(MAX_KP);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t state, next_state;

  logic [51:0]     mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic            empty, full;
  logic            eligible;
  logic            wr_en, rd_en, drop, clr;
  logic [51:0]     rec;

  assign rec   = {i_x, i_y, i_score, i_cos, i_sin};
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

`ifdef KPC_SCORE_THRESH_EN
  assign eligible = (i_score >= i_min_score);
`else
  assign eligible = 1'b1;
`endif

  assign o_valid = !empty;
  assign o_data  = empty ? 52'd0 : mem[rd_ptr[ADDR_W-1:0]];
  assign rd_en   = o_valid && i_rd_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode, push/drop decisions and handshake outputs
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    drop       = 1'b0;
    clr        = 1'b0;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          clr        = 1'b1;
          next_state = COLLECT;
        end
      end
      COLLECT: begin
        // full is the registered flag: a same-cycle pop does not make room
        if (i_flag && eligible) begin
          if (!full && (o_kp_count < MAX_KP_C)) wr_en = 1'b1;
          else                                  drop  = 1'b1;
        end
        if (i_end) next_state = DRAIN;
      end
      DRAIN: begin
        if (empty) begin
          o_done     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FIFO pointers; push and pop may happen in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage, no reset needed since o_data is masked while empty
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= rec;
  end

  // Per-frame keypoint count and sticky overflow, cleared on frame start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_kp_count <= '0;
      o_overflow <= 1'b0;
    end else if (clr) begin
      o_kp_count <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) o_kp_count <= o_kp_count + 16'd1;
      if (drop)  o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypoint_collector.sv
// Self-checking bench for keypoint_collector with a small FIFO and a low
// keypoint limit so both drop conditions are reached quickly.
module tb_keypoint_collector;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int MAX_KP = 10;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0, i_end = 1'b0, i_flag = 1'b0;
  logic [9:0]  i_x = '0, i_y = '0;
  logic [7:0]  i_score = '0;
  logic [11:0] i_cos = '0, i_sin = '0;
  logic        i_rd_ready = 1'b0;
  logic        o_ready, o_valid, o_overflow, o_done;
  logic [51:0] o_data;
  logic [15:0] o_kp_count;
`ifdef KPC_SCORE_THRESH_EN
  logic [7:0]  i_min_score = '0;
`endif

  keypoint_collector #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_KP(MAX_KP)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_end      (i_end),
    .i_flag     (i_flag),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_score    (i_score),
    .i_cos      (i_cos),
    .i_sin      (i_sin),
`ifdef KPC_SCORE_THRESH_EN
    .i_min_score(i_min_score),
`endif
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_rd_ready (i_rd_ready),
    .o_kp_count (o_kp_count),
    .o_overflow (o_overflow),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: records the DUT should hold, in arrival order
  logic [51:0] exp_q[$];
  logic [51:0] staged;
  bit          staged_v = 0;
  bit          m_collect = 0;
  int          m_count = 0;
  bit          m_ovf = 0;
  logic [7:0]  min_score = '0;
  int          done_cnt = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [51:0] mk(input int x, input int y, input int sc);
    mk = {10'(x), 10'(y), 8'(sc), 12'h3a5, 12'hc17};
  endfunction

  function automatic logic [51:0] rnd_rec();
    logic [51:0] r;
    r[31:0]  = $urandom;
    r[51:32] = 20'($urandom);
    return r;
  endfunction

  // One clock cycle of stimulus plus the reference model's view of it
  task automatic cyc(input bit st, input bit en, input bit fl, input bit rr, input logic [51:0] rec);
    @(posedge i_clk);
    #1;
    if (staged_v) begin
      exp_q.push_back(staged);
      staged_v = 0;
    end
    i_start = st; i_end = en; i_flag = fl; i_rd_ready = rr;
    i_x = rec[51:42]; i_y = rec[41:32]; i_score = rec[31:24];
    i_cos = rec[23:12]; i_sin = rec[11:0];
`ifdef KPC_SCORE_THRESH_EN
    i_min_score = min_score;
`endif
    if (!m_collect) begin
      if (st) begin
        m_collect = 1; m_count = 0; m_ovf = 0;
      end
    end else begin
      if (fl && rec[31:24] >= min_score) begin
        if (exp_q.size() < DEPTH && m_count < MAX_KP) begin
          staged = rec; staged_v = 1; m_count++;
        end else begin
          m_ovf = 1;
        end
      end
      if (en) m_collect = 0;
    end
  endtask

  // Keep clocking until o_done, then check the frame summary outputs
  task automatic finish_frame(input string nm, input int exp_cnt, input bit exp_ovf, input bit rr_always);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      cyc(0, 0, 0, rr_always ? 1'b1 : ($urandom_range(0, 3) != 0), rnd_rec());
      n++;
    end
    cyc(0, 0, 0, 1'b1, rnd_rec());
    chk({nm, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_ready"}, 64'(o_ready), 64'd1);
    chk({nm, "_done_pulse_width"}, 64'(o_done), 64'd0);
    chk({nm, "_kp_count"}, 64'(o_kp_count), 64'(exp_cnt));
    chk({nm, "_overflow"}, 64'(o_overflow), 64'(exp_ovf));
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    exp_q.delete();
    staged_v = 0; m_collect = 0; m_count = 0; m_ovf = 0;
    i_start = 0; i_end = 0; i_flag = 0; i_rd_ready = 0;
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_kp_count", 64'(o_kp_count), 64'd0);
    chk("rst_overflow", 64'(o_overflow), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(o_ready), 64'd1);
  endtask

  // Monitor: compares every popped head against the model queue
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_record: got %h, expected no record (t=%0t)", o_data, $time);
        end else if (i_rd_ready) begin
          chk("record", 64'(o_data), 64'(exp_q.pop_front()));
        end
      end else begin
        chk("pending_vs_valid", 64'(exp_q.size()), 64'd0);
        chk("empty_data", 64'(o_data), 64'd0);
      end
      if (o_done) begin
        done_cnt++;
        chk("done_drained", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  initial begin
    int n;
    bit rr_bias;
    do_reset();

    // Three points, consumer always ready
    cyc(1, 0, 0, 1, '0);
    cyc(0, 0, 1, 1, mk(40, 40, 30));
    chk("collect_not_ready", 64'(o_ready), 64'd0);
    cyc(0, 0, 1, 1, mk(41, 50, 25));
    cyc(0, 0, 1, 1, mk(100, 200, 60));
    cyc(0, 1, 0, 1, '0);
    finish_frame("three_pts", 3, 0, 1);

    // Six flags into a four-deep FIFO with the consumer stalled
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, mk(k, k + 1, 100 + k));
    cyc(0, 1, 0, 0, '0);
    finish_frame("fifo_full", 4, 1, 1);

    // Twelve flags against the per-frame limit with the consumer ready
    cyc(1, 0, 0, 1, '0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, 1, mk(200 + k, k, 90));
    cyc(0, 1, 0, 1, '0);
    finish_frame("max_kp", MAX_KP, 1, 1);

    // Full FIFO with a flag and a pop in the same cycle, then a flag that fits
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, mk(300 + k, 7, 50));
    cyc(0, 0, 1, 1, mk(999, 9, 9));
    cyc(0, 0, 1, 0, mk(500, 11, 77));
    cyc(0, 1, 0, 0, '0);
    finish_frame("full_pop", 5, 1, 0);

    // Reset mid-frame with three records queued, then a flag before i_start
    cyc(1, 0, 0, 0, '0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, mk(10 + k, 20, 44));
    do_reset();
    cyc(0, 0, 1, 1, mk(1, 2, 3));
    cyc(0, 1, 1, 1, mk(4, 5, 6));
    cyc(0, 0, 0, 1, '0);
    chk("idle_flag_ignored", 64'(o_valid), 64'd0);
    chk("idle_kp_count", 64'(o_kp_count), 64'd0);

`ifdef KPC_SCORE_THRESH_EN
    min_score = 8'd40;
    cyc(1, 0, 0, 1, '0);
    cyc(0, 0, 1, 1, mk(1, 1, 30));
    cyc(0, 0, 1, 1, mk(2, 2, 40));
    cyc(0, 0, 1, 1, mk(3, 3, 55));
    cyc(0, 1, 0, 1, '0);
    finish_frame("score_thresh", 2, 0, 1);
`endif

    // Randomized frames, including stray i_start and a flag on i_end
    for (int f = 0; f < 30; f++) begin
`ifdef KPC_SCORE_THRESH_EN
      min_score = 8'($urandom_range(0, 160));
`endif
      rr_bias = ($urandom_range(0, 1) == 1);
      cyc(1, 0, 0, 1'($urandom_range(0, 1)), rnd_rec());
      n = $urandom_range(2, 25);
      for (int k = 0; k < n; k++)
        cyc($urandom_range(0, 9) == 0, 0, $urandom_range(0, 9) < 6,
            rr_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0), rnd_rec());
      cyc(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_rec());
      finish_frame("rand_frame", m_count, m_ovf, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypoint_collector.md
Name: keypoint_collector

Overview:
- Sink for the FAST detector's per-pixel output stream. Captures only flagged keypoints as packed 52-bit records into an internal first-word-fall-through FIFO.
- Hands the records to the descriptor/host side over a valid/ready interface.
- Brackets each frame with the detector's start/end pulses and reports a per-frame keypoint count and an overflow status.

Parameters:
- DEPTH, 256, FIFO entries; must be a power of 2.
- ADDR_W, 8, log2(DEPTH).
- MAX_KP, 500, maximum keypoints accepted per frame; further flagged points are dropped.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  frame-start pulse from the detector
- i_end  in  1  frame-end pulse from the detector, on the last coordinate
- i_flag  in  1  keypoint flag; the record fields below are valid in the same cycle
- i_x  in  10  column
- i_y  in  10  row
- i_score  in  8  FAST score
- i_cos  in  12  orientation cosine
- i_sin  in  12  orientation sine
- o_ready  out  1  high in IDLE: collector can accept a new frame
- o_valid  out  1  FIFO head valid
- o_data  out  52  head record {x[51:42], y[41:32], score[31:24], cos[23:12], sin[11:0]}
- i_rd_ready  in  1  consumer accepts the head when o_valid is also high
- o_kp_count  out  16  keypoints accepted in the current or last frame
- o_overflow  out  1  sticky: at least one keypoint dropped this frame
- o_done  out  1  one-cycle pulse when a frame is fully drained

Behaviour:
- Reset values: all outputs 0, except o_ready = 1 once out of reset. FIFO empty, state IDLE.
- Reset is legal mid-frame. It discards FIFO contents and counters, and the block returns to IDLE.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - o_ready = 1.
  - i_start → COLLECT. Same cycle clears o_kp_count and o_overflow.
  - i_flag and i_end are ignored in IDLE.
- COLLECT: write occurs when i_flag = 1, FIFO not full, and o_kp_count < MAX_KP.
  - On write: record pushed and o_kp_count incremented, both registered on the next edge.
  - i_flag with FIFO full or o_kp_count == MAX_KP: record dropped, o_overflow set to 1.
  - Full is the registered flag. A simultaneous pop does not free space for the same-cycle write; that write is dropped.
  - i_end → DRAIN. A flagged record in the same cycle as i_end is still captured.
  - i_start while in COLLECT or DRAIN is ignored.
- DRAIN:
  - No writes.
  - When the FIFO is empty (registered), pulse o_done for one cycle and go to IDLE.
  - o_kp_count and o_overflow hold their values until the next i_start.
- Read side, independent of state:
  - o_valid = !empty.
  - o_data shows the head combinationally (FWFT) and is 0 when empty.
  - Pop occurs when o_valid & i_rd_ready.
  - Pop and push in the same cycle are both performed; occupancy is unchanged.
  - A pop when empty is impossible, since it is gated by o_valid.
- Pointers are ADDR_W+1 bits and wrap modulo 2·DEPTH.
  - full: MSBs differ and the rest are equal.
  - empty: pointers equal.
- o_kp_count saturates at MAX_KP. Records leave the FIFO in arrival order (raster order).
- Latency: a keypoint presented at cycle t has o_valid = 1 at t+1 if the FIFO was empty.

Optional Feature:
- Macro: KPC_SCORE_THRESH_EN.
- Defined:
  - Adds input port i_min_score (8 bits).
  - A flagged point with i_score < i_min_score is silently discarded. It does not count and does not set o_overflow.
  - i_min_score is sampled every cycle.
- Undefined: port absent; every flagged point is eligible.

Test Plan:
- Reset then i_start; 3 flagged points at (40,40,score 30), (41,50,25), (100,200,60); i_end; i_rd_ready = 1 throughout → 3 records emitted in order, o_kp_count = 3, o_overflow = 0, then o_done pulse one cycle after the FIFO empties, o_ready = 1.
- DEPTH = 4, i_rd_ready = 0, 6 consecutive flags → 4 stored, o_overflow = 1, o_kp_count = 4. Then release i_rd_ready after i_end → 4 records, o_done.
- MAX_KP = 2, 5 flags with i_rd_ready = 1 → only the first 2 records emitted, o_kp_count = 2, o_overflow = 1.
- FIFO full, with i_flag and a pop in the same cycle → pop occurs, new record dropped, o_overflow = 1. Next cycle a flag is accepted.
- Reset asserted mid-COLLECT with 3 records queued → o_valid = 0, o_kp_count = 0, state IDLE. A flag arriving before i_start is ignored.
- With KPC_SCORE_THRESH_EN and i_min_score = 40, scores 30/40/55 → 2 records (40, 55), o_kp_count = 2, o_overflow = 0.
